// File: rtl/cmlk_gate_pulse_gen_if.sv
// cmlk_gate_pulse_gen_if: run control, timing parameters and pulse outputs of the gate pulse generator
interface cmlk_gate_pulse_gen_if #(
  parameter int CNT_W = 32,
  parameter int M_W = 8
);
  logic enable;
  logic param_update;
  logic [CNT_W-1:0] laser_period;
  logic [CNT_W-1:0] laser_width;
  logic [CNT_W-1:0] gate_delay_a;
  logic [CNT_W-1:0] gate_width_a;
  logic [CNT_W-1:0] gate_delay_b;
  logic [CNT_W-1:0] gate_width_b;
  logic [M_W-1:0] tim_cycles_m;
  logic [M_W-1:0] delay_step;
  logic laser_o;
  logic gate_a_o;
  logic gate_b_o;
  logic period_start_o;
  logic step_done_o;
  logic [CNT_W-1:0] delay_offset_o;
  logic busy_o;
  modport master (
    output enable, param_update, laser_period, laser_width, gate_delay_a, gate_width_a,
           gate_delay_b, gate_width_b, tim_cycles_m, delay_step,
    input laser_o, gate_a_o, gate_b_o, period_start_o, step_done_o, delay_offset_o, busy_o
  );
  modport slave (
    input enable, param_update, laser_period, laser_width, gate_delay_a, gate_width_a,
          gate_delay_b, gate_width_b, tim_cycles_m, delay_step,
    output laser_o, gate_a_o, gate_b_o, period_start_o, step_done_o, delay_offset_o, busy_o
  );
endinterface

// File: rtl/cmlk_gate_pulse_gen.sv
// cmlk_gate_pulse_gen: laser trigger and swept range gates; define CMLK_GATE_B_SWEEP_EN to sweep gate B too
module cmlk_gate_pulse_gen #(
  parameter int CNT_W = 32,
  parameter int M_W = 8,
  parameter logic [CNT_W-1:0] SWEEP_MAX = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic rst_n,
  cmlk_gate_pulse_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] lw;
    logic [CNT_W-1:0] da;
    logic [CNT_W-1:0] wa;
    logic [CNT_W-1:0] db;
    logic [CNT_W-1:0] wb;
    logic [M_W-1:0] m;
    logic [M_W-1:0] step;
  } cfg_t;
  state_t state;
  cfg_t shadow, act, in_cfg, sh_n;
  logic pending, pend_n, step_flag, running, boundary, apply, sweep_hit;
  logic [CNT_W-1:0] cnt, offset, off_sat;
  logic [M_W-1:0] mloop;
  logic [CNT_W:0] da_sum, db_sum, a_end, b_end, off_sum, cnt_x;
  assign in_cfg = {bus.laser_period, bus.laser_width, bus.gate_delay_a, bus.gate_width_a,
                   bus.gate_delay_b, bus.gate_width_b, bus.tim_cycles_m, bus.delay_step};
  // an update arriving on a boundary cycle is applied on that same boundary
  assign sh_n = bus.param_update ? in_cfg : shadow;
  assign pend_n = bus.param_update | pending;
  assign running = state != IDLE;
  assign boundary = running && cnt == act.period;
  assign apply = pend_n && (!running || boundary);
  assign sweep_hit = mloop == act.m - M_W'(1);
  assign cnt_x = {1'b0, cnt};
  // gate windows use one extra bit so delay+offset+width never wraps back into range
  assign da_sum = {1'b0, act.da} + {1'b0, offset};
`ifdef CMLK_GATE_B_SWEEP_EN
  assign db_sum = {1'b0, act.db} + {1'b0, offset};
`else
  assign db_sum = {1'b0, act.db};
`endif
  assign a_end = da_sum + {1'b0, act.wa};
  assign b_end = db_sum + {1'b0, act.wb};
  assign off_sum = {1'b0, offset} + (CNT_W+1)'(act.step);
  assign off_sat = off_sum > {1'b0, SWEEP_MAX} ? SWEEP_MAX : off_sum[CNT_W-1:0];
  // run FSM, period counter, parameter hand-over, sweep and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      offset <= '0;
      mloop <= '0;
      pending <= 1'b0;
      step_flag <= 1'b0;
      shadow <= '0;
      act <= '0;
      bus.laser_o <= 1'b0;
      bus.gate_a_o <= 1'b0;
      bus.gate_b_o <= 1'b0;
      bus.period_start_o <= 1'b0;
      bus.step_done_o <= 1'b0;
      bus.busy_o <= 1'b0;
    end else begin
      shadow <= sh_n;
      pending <= pend_n;
      state <= bus.enable ? RUN : (running && !boundary) ? DRAIN : IDLE;
      cnt <= (running && !boundary) ? cnt + CNT_W'(1) : '0;
      bus.busy_o <= bus.enable || (running && !boundary);
      bus.laser_o <= running && cnt < act.lw;
      bus.gate_a_o <= running && cnt_x >= da_sum && cnt_x < a_end;
      bus.gate_b_o <= running && cnt_x >= db_sum && cnt_x < b_end;
      bus.period_start_o <= running && cnt == '0;
      bus.step_done_o <= running && cnt == '0 && step_flag;
      if (!running || cnt == '0) step_flag <= 1'b0;
      if (apply) begin
        act <= sh_n;
        pending <= 1'b0;
        offset <= '0;
        mloop <= '0;
      end else if (boundary && bus.enable && act.m != '0) begin
        mloop <= sweep_hit ? '0 : mloop + M_W'(1);
        if (sweep_hit) begin
          offset <= off_sat;
          step_flag <= 1'b1;
        end
      end
    end
  end
  assign bus.delay_offset_o = offset;
endmodule

// File: doc/cmlk_gate_pulse_gen.md
Name: cmlk_gate_pulse_gen

Overview:
Downstream consumer of the clamped, load-latched timing parameters. Generates the periodic laser trigger and two range-gate pulses (A, B) from a free-running period counter. Sweeps the gate A delay by a programmable step every M laser periods. Parameter changes are applied only on period boundaries, so outputs never glitch mid-period.

Parameters:
CNT_W, 32, width of period counter and all timing fields
M_W, 8, width of tim_cycles_m and delay_step
SWEEP_MAX, 32'hFFFF_FFFF, saturation ceiling of the accumulated delay offset

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  level; 1 = run, 0 = stop at end of current period
param_update  in  1  one-cycle pulse: shadow inputs valid, apply at next period boundary
laser_period  in  CNT_W  period terminal count; period length = laser_period+1 clk
laser_width  in  CNT_W  laser pulse high length in clk
gate_delay_a  in  CNT_W  gate A base delay from period start
gate_width_a  in  CNT_W  gate A high length
gate_delay_b  in  CNT_W  gate B delay (not swept unless optional feature)
gate_width_b  in  CNT_W  gate B high length
tim_cycles_m  in  M_W  periods per sweep step; 0 = sweep disabled
delay_step  in  M_W  offset increment per sweep step, clk units
laser_o  out  1  laser trigger
gate_a_o  out  1  gate A
gate_b_o  out  1  gate B
period_start_o  out  1  one-cycle pulse at start of each period
step_done_o  out  1  one-cycle pulse when offset increments
delay_offset_o  out  CNT_W  current accumulated gate A offset
busy_o  out  1  1 while in RUN or DRAIN

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, state IDLE, cnt=0, offset=0, period counter in M-loop=0, pending flag 0, active register set = 0.
- Two register sets: shadow (captured from inputs on param_update) and active (used by counters). param_update sets pending; if seen in IDLE, copy takes effect immediately (next cycle).
- States: IDLE -> RUN when enable=1 (cnt=0 that cycle, active<=shadow if pending, pending cleared). RUN: cnt increments; at cnt==laser_period cnt<=0 (boundary). At boundary: if pending, active<=shadow, pending<=0, offset<=0, M-loop<=0. If enable=0 at boundary -> IDLE (also via DRAIN: RUN->DRAIN when enable falls mid-period, DRAIN->IDLE at boundary; enable reasserted during DRAIN returns to RUN, no restart).
- Outputs registered, 1-cycle latency from cnt: laser_o(t+1)=(cnt(t)<laser_width); gate_a_o(t+1)=(cnt>=Da)&&(cnt<Da+gate_width_a) with Da=gate_delay_a+offset; gate_b_o likewise with gate_delay_b. All sums computed 33-bit (no wrap); Da>=2^32 -> gate A never asserts. period_start_o(t+1)=(cnt(t)==0 in RUN/DRAIN).
- Width 0 -> output stays 0. Width > remaining period -> truncated at boundary (no carry into next period).
- laser_period=0: period of 1 clk; laser_o constant 1 if laser_width>=1.
- Sweep: at each boundary with tim_cycles_m!=0, M-loop increments; when M-loop==tim_cycles_m-1, M-loop<=0, offset<=min(offset+delay_step, SWEEP_MAX), step_done_o pulse (asserted with next period_start_o). Saturated offset holds; step_done_o still pulses.
- Pending update and sweep at same boundary: update wins, offset=0, no step_done_o.
- IDLE: all pulse outputs 0 within 1 cycle; offset retained until update or reset.
- Reset mid-period: immediate return to reset values next cycle.

Optional Feature:
CMLK_GATE_B_SWEEP_EN: defined -> gate B delay = gate_delay_b+offset (same offset, same 33-bit rules). Undefined -> gate B delay fixed at gate_delay_b.

Test Plan:
- period=9, laser_width=3, enable=1 -> laser_o high 3 of every 10 clk, period_start_o every 10 clk, first 1 cycle after RUN entry.
- delay_a=4, width_a=2, M=2, step=1 -> gate A at cnt 4-5 periods 0-1, 5-6 periods 2-3, step_done_o every 2 periods, delay_offset_o 0,1,2.
- param_update mid-period (period 9 -> 19) -> current period completes 10 clk, next is 20 clk, offset reset to 0.
- enable dropped at cnt=3 -> busy_o stays 1 until cnt=9, then outputs 0, state IDLE; re-enable restarts cnt=0.
- delay_a=32'hFFFF_FFF0, step=255, M=1 -> offset saturates at 32'hFFFF_FFFF, gate A never asserts, no wrap.
- width_a=50 with period=9, delay 5 -> gate A high cnt 5-9 only; macro on: gate B shifts with offset; off: fixed.
